// File: rtl/dbg_bus_pkg.sv
// Shared definitions for the debug data bus target: FSM states and command beat layout.
// Pure declarations; no logic, no latency.
package dbg_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WDATA   = 3'd1,
        ST_WACC    = 3'd2,
        ST_RACC    = 3'd3,
        ST_TURN    = 3'd4,
        ST_DRIVE   = 3'd5,
        ST_RELEASE = 3'd6
    } state_e;

    localparam int CMD_ADDR_LSB = 0;

    // Write flag sits in the MSB of a command beat.
    function automatic int cmd_wr_bit(input int data_w);
        return data_w - 1;
    endfunction

endpackage

// File: rtl/dbg_wait_timer.sv
// Clearable up-counter bounding register-side wait states; expire is high in the TIMEOUT-th counted cycle.
// Zero latency on expire (decoded from the count register); no backpressure.
module dbg_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dbg_bus_target.sv
// Responder on the half-duplex debug bus: decodes command/data beats, runs register accesses, returns read data.
// All outputs registered; read ack 2 cycles after reg_ready, write ack 1 cycle after; register side stalls via reg_ready with timeout.
module dbg_bus_target
    import dbg_bus_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              bus_strobe,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              bus_ack,
    output logic              bus_err,
    output logic              busy,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_ready
);
    localparam int WR_BIT = cmd_wr_bit(DATA_W);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] bus_out_q, bus_out_d;
    logic              bus_oe_q, bus_oe_d;
    logic              bus_ack_q, bus_ack_d;
    logic              bus_err_q, bus_err_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
    logic              reg_we_q, reg_we_d;
    logic              reg_re_q, reg_re_d;

    logic in_acc;
    logic tmo_expire;

    assign in_acc = (state_q == ST_WACC) || (state_q == ST_RACC);

    dbg_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!in_acc),
        .en     (in_acc),
        .expire (tmo_expire)
    );

    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = reg_we_q;
        reg_re_d    = reg_re_q;
        bus_out_d   = '0;
        bus_oe_d    = 1'b0;
        bus_ack_d   = 1'b0;
        bus_err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus_strobe) begin
                    reg_addr_d = bus_in[CMD_ADDR_LSB +: ADDR_W];
                    if (bus_in[WR_BIT]) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d  = ST_RACC;
                        reg_re_d = 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                if (bus_strobe) begin
                    reg_wdata_d = bus_in;
                    reg_we_d    = 1'b1;
                    state_d     = ST_WACC;
                end
            end
            // reg_ready on the expiry cycle still completes the access.
            ST_WACC: begin
                if (reg_ready) begin
                    reg_we_d  = 1'b0;
                    bus_ack_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (tmo_expire) begin
                    reg_we_d  = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_RACC: begin
                if (reg_ready) begin
                    rdata_d  = reg_rdata;
                    reg_re_d = 1'b0;
                    state_d  = ST_TURN;
                end else if (tmo_expire) begin
                    reg_re_d  = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            // A master still driving during turnaround spoils the read: flag it instead of acking.
            ST_TURN: begin
                state_d   = ST_DRIVE;
                bus_oe_d  = 1'b1;
                bus_out_d = rdata_q;
                bus_err_d = bus_strobe;
                bus_ack_d = !bus_strobe;
            end
            ST_DRIVE: begin
                state_d   = ST_RELEASE;
                bus_err_d = bus_strobe;
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rdata_q     <= '0;
            bus_out_q   <= '0;
            bus_oe_q    <= 1'b0;
            bus_ack_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            bus_out_q   <= bus_out_d;
            bus_oe_q    <= bus_oe_d;
            bus_ack_q   <= bus_ack_d;
            bus_err_q   <= bus_err_d;
            busy_q      <= busy_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
        end
    end

    assign bus_out   = bus_out_q;
    assign bus_oe    = bus_oe_q;
    assign bus_ack   = bus_ack_q;
    assign bus_err   = bus_err_q;
    assign busy      = busy_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;

endmodule
